// File: rtl/calc1_port_driver_if.sv
// calc1_port_driver_if: operation input, calc1 port bus and held-result signals of one port driver
interface calc1_port_driver_if;
    logic        in_valid;
    logic        in_ready;
    logic [0:3]  in_cmd;
    logic [0:31] in_op1;
    logic [0:31] in_op2;
    logic [0:3]  req_cmd_out;
    logic [0:31] req_data_out;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:1]  rsp_code;
    logic [0:31] rsp_data;
    logic        rsp_timeout;
    logic [0:7]  timeout_cnt;
    modport slave (
        input  in_valid, in_cmd, in_op1, in_op2, out_resp, out_data, rsp_ready,
        output in_ready, req_cmd_out, req_data_out, rsp_valid, rsp_code, rsp_data, rsp_timeout, timeout_cnt
    );
    modport master (
        output in_valid, in_cmd, in_op1, in_op2, out_resp, out_data, rsp_ready,
        input  in_ready, req_cmd_out, req_data_out, rsp_valid, rsp_code, rsp_data, rsp_timeout, timeout_cnt
    );
endinterface

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: serialises one operation onto a calc1 port and returns its response or a timeout
module calc1_port_driver #(
    parameter int TIMEOUT_CYCLES = 10
) (
    input logic c_clk,
    input logic reset,
    calc1_port_driver_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, OPND2, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic [0:31] op2_q;
    logic [0:7]  wait_cnt;
    logic        accept, resp_hit, wait_expired;
    // next state; a result only leaves RESP once it has actually been presented
    always_comb begin
        accept       = state_q == IDLE && bus.in_valid;
        resp_hit     = state_q == WAIT && bus.out_resp != 2'd0;
        wait_expired = state_q == WAIT && wait_cnt == 8'(TIMEOUT_CYCLES - 1);
        state_d      = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (bus.in_cmd != 4'd0 ? CMD : RESP) : IDLE;
            CMD:     state_d = OPND2;
            OPND2:   state_d = WAIT;
            WAIT:    state_d = (resp_hit || wait_expired) ? RESP : WAIT;
            RESP:    state_d = (bus.rsp_valid && bus.rsp_ready) ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge c_clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    // registered outputs derived from the state being entered, plus result capture
    always_ff @(posedge c_clk) begin
        if (reset) begin
            bus.in_ready     <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.req_cmd_out  <= '0;
            bus.req_data_out <= '0;
            bus.rsp_code     <= '0;
            bus.rsp_data     <= '0;
            bus.rsp_timeout  <= 1'b0;
            bus.timeout_cnt  <= '0;
            op2_q            <= '0;
            wait_cnt         <= '0;
        end else begin
            bus.in_ready     <= state_d == IDLE;
            bus.rsp_valid    <= state_d == RESP && state_q != IDLE;
            bus.req_cmd_out  <= state_d == CMD ? bus.in_cmd : 4'd0;
            bus.req_data_out <= state_d == CMD ? bus.in_op1 : state_d == OPND2 ? op2_q : 32'd0;
            wait_cnt         <= state_q == WAIT ? wait_cnt + 8'd1 : 8'd0;
            if (accept) op2_q <= bus.in_op2;
            if (accept && bus.in_cmd == 4'd0) begin
                bus.rsp_code    <= 2'd0;
                bus.rsp_data    <= 32'd0;
                bus.rsp_timeout <= 1'b0;
            end else if (resp_hit) begin
                bus.rsp_code    <= bus.out_resp;
                bus.rsp_data    <= bus.out_data;
                bus.rsp_timeout <= 1'b0;
            end else if (wait_expired) begin
                bus.rsp_code    <= 2'd0;
                bus.rsp_data    <= 32'd0;
                bus.rsp_timeout <= 1'b1;
                bus.timeout_cnt <= bus.timeout_cnt == 8'hFF ? 8'hFF : bus.timeout_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_calc1_port_driver.sv
// tb_calc1_port_driver: directed stimulus with a timeline reference model checked every cycle
module tb_calc1_port_driver;
    localparam int T = 10;
    logic c_clk = 1'b0;
    logic reset;
    always #5 c_clk = ~c_clk;
    calc1_port_driver_if ifc();
    calc1_port_driver #(.TIMEOUT_CYCLES(T)) dut (.c_clk(c_clk), .reset(reset), .bus(ifc));

    int n_checks;
    int n_fail;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // stub calc1 port behaviour: {code, data}
    function automatic logic [33:0] calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (c)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            end
            4'd2:    return a < b ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5:    return {2'd1, a << b[4:0]};
            4'd6:    return {2'd1, a >> b[4:0]};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    // reference model: per operation, accept cycle and the cycle the result is decided
    int          cyc;
    int          acc;
    int          vf;
    bit          m_busy;
    bit          m_started;
    logic [3:0]  m_cmd;
    logic [31:0] m_op1, m_op2, m_data;
    logic [1:0]  m_code;
    logic        m_to;
    int          m_tcnt;
    always @(posedge c_clk) begin
        cyc++;
        if (reset) begin
            m_busy = 0; m_code = 0; m_data = 0; m_to = 0; m_tcnt = 0; vf = -1; m_started = 1;
        end else if (!m_busy) begin
            if (ifc.in_valid) begin
                m_busy = 1; acc = cyc; vf = -1;
                m_cmd = ifc.in_cmd; m_op1 = ifc.in_op1; m_op2 = ifc.in_op2;
                if (m_cmd == 0) begin
                    m_code = 0; m_data = 0; m_to = 0; vf = cyc + 1;
                end
            end
        end else if (vf < 0) begin
            if (cyc >= acc + 3 && ifc.out_resp != 0) begin
                m_code = ifc.out_resp; m_data = ifc.out_data; m_to = 0; vf = cyc;
            end else if (cyc == acc + 2 + T) begin
                m_code = 0; m_data = 0; m_to = 1; vf = cyc;
                m_tcnt = m_tcnt < 255 ? m_tcnt + 1 : 255;
            end
        end else if (cyc > vf && ifc.rsp_ready) begin
            m_busy = 0;
        end
    end

    // compare process
    logic        e_valid, e_cyc0, e_cyc1;
    logic [3:0]  e_cmd;
    logic [31:0] e_data;
    always @(negedge c_clk) begin
        if (m_started) begin
            e_valid = m_busy && vf >= 0 && cyc >= vf;
            e_cyc0  = m_busy && m_cmd != 0 && cyc == acc;
            e_cyc1  = m_busy && m_cmd != 0 && cyc == acc + 1;
            e_cmd   = e_cyc0 ? m_cmd : 4'd0;
            e_data  = e_cyc0 ? m_op1 : e_cyc1 ? m_op2 : 32'd0;
            check("m_in_ready", ifc.in_ready, !m_busy);
            check("m_rsp_valid", ifc.rsp_valid, e_valid);
            check("m_req_cmd", ifc.req_cmd_out, e_cmd);
            check("m_req_data", ifc.req_data_out, e_data);
            check("m_timeout_cnt", ifc.timeout_cnt, m_tcnt);
            if (e_valid) begin
                check("m_rsp_code", ifc.rsp_code, m_code);
                check("m_rsp_data", ifc.rsp_data, m_data);
                check("m_rsp_timeout", ifc.rsp_timeout, m_to);
            end
        end
    end

    // offer one operation (called at a negedge); d = WAIT cycles before the stub answers, -1 = never
    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input int d,
                         input int exp_lat, output logic [1:0] code, output logic [31:0] data, output logic to);
        logic [33:0] r;
        int k;
        bit seen;
        r = calc(cmd, a, b);
        ifc.in_valid = 1; ifc.in_cmd = cmd; ifc.in_op1 = a; ifc.in_op2 = b;
        for (int n = 0; n < 50 && !ifc.in_ready; n++) @(negedge c_clk);
        check("accept", ifc.in_ready, 1);
        seen = 0;
        k = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge c_clk);
            k = i;
            if (i == 0) begin
                ifc.in_valid = 0; ifc.out_resp = 0; ifc.out_data = 0;
            end
            if (d >= 0 && i == 3 + d) begin
                ifc.out_resp = 0; ifc.out_data = 0;
            end
            if (ifc.rsp_valid) seen = 1;
            else if (d >= 0 && i == 2 + d) begin
                ifc.out_resp = r[33:32]; ifc.out_data = r[31:0];
            end
        end
        check("rsp_latency", k, exp_lat);
        code = ifc.rsp_code; data = ifc.rsp_data; to = ifc.rsp_timeout;
    endtask

    task automatic finish_rsp(input int hold);
        repeat (hold) @(negedge c_clk);
        ifc.rsp_ready = 1;
        @(negedge c_clk);
        ifc.rsp_ready = 0;
    endtask

    logic [1:0]  code;
    logic [31:0] data;
    logic        to;
    initial begin
        reset = 1;
        ifc.in_valid = 0; ifc.in_cmd = 0; ifc.in_op1 = 0; ifc.in_op2 = 0;
        ifc.out_resp = 0; ifc.out_data = 0; ifc.rsp_ready = 0;
        repeat (2) @(posedge c_clk);
        @(negedge c_clk);
        check("reset_in_ready", ifc.in_ready, 1);
        check("reset_req_cmd", ifc.req_cmd_out, 0);
        check("reset_req_data", ifc.req_data_out, 0);
        check("reset_rsp_valid", ifc.rsp_valid, 0);
        check("reset_rsp_code", ifc.rsp_code, 0);
        check("reset_rsp_data", ifc.rsp_data, 0);
        check("reset_rsp_timeout", ifc.rsp_timeout, 0);
        check("reset_timeout_cnt", ifc.timeout_cnt, 0);
        reset = 0;
        issue(4'd1, 32'h1, 32'h1FFFFFFF, 0, 3, code, data, to);
        check("add_code", code, 1);
        check("add_data", data, 32'h20000000);
        check("add_timeout", to, 0);
        finish_rsp(0);
        for (int p = 0; p < 4; p++) begin
            issue(4'd1, 32'h80000000, 32'h80000000, p, 3 + p, code, data, to);
            check("ovf_code", code, 2);
            check("ovf_timeout", to, 0);
            finish_rsp(1);
        end
        issue(4'd0, 32'h1234, 32'h0, -1, 1, code, data, to);
        check("noop_code", code, 0);
        check("noop_data", data, 0);
        check("noop_timeout", to, 0);
        finish_rsp(0);
        issue(4'd2, 32'd10, 32'd3, 1, 4, code, data, to);
        check("sub_data", data, 7);
        finish_rsp(2);
        issue(4'd5, 32'd1, 32'd4, 0, 3, code, data, to);
        check("shl_data", data, 16);
        finish_rsp(0);
        issue(4'd1, 32'd5, 32'd6, -1, 12, code, data, to);
        check("tmo_timeout", to, 1);
        check("tmo_code", code, 0);
        check("tmo_data", data, 0);
        check("tmo_cnt", ifc.timeout_cnt, 1);
        ifc.out_resp = 2'd1; ifc.out_data = 32'hDEAD;
        @(negedge c_clk);
        check("late_code", ifc.rsp_code, 0);
        check("late_data", ifc.rsp_data, 0);
        finish_rsp(1);
        check("late_idle_ready", ifc.in_ready, 1);
        issue(4'd1, 32'd2, 32'd3, 1, 4, code, data, to);
        check("after_late_code", code, 1);
        check("after_late_data", data, 5);
        check("after_late_cnt", ifc.timeout_cnt, 1);
        finish_rsp(0);
        issue(4'd1, 32'd100, 32'd23, 0, 3, code, data, to);
        check("bp_first_data", data, 123);
        ifc.in_valid = 1; ifc.in_cmd = 4'd2; ifc.in_op1 = 32'd50; ifc.in_op2 = 32'd8;
        repeat (5) begin
            @(negedge c_clk);
            check("bp_in_ready", ifc.in_ready, 0);
            check("bp_rsp_valid", ifc.rsp_valid, 1);
            check("bp_rsp_data", ifc.rsp_data, 123);
        end
        ifc.rsp_ready = 1;
        @(negedge c_clk);
        ifc.rsp_ready = 0;
        check("bp_release_ready", ifc.in_ready, 1);
        check("bp_release_valid", ifc.rsp_valid, 0);
        issue(4'd2, 32'd50, 32'd8, 0, 3, code, data, to);
        check("bp_second_data", data, 42);
        finish_rsp(0);
        ifc.in_valid = 1; ifc.in_cmd = 4'd1; ifc.in_op1 = 32'd5; ifc.in_op2 = 32'd5;
        @(negedge c_clk);
        ifc.in_valid = 0;
        repeat (4) @(negedge c_clk);
        reset = 1;
        @(negedge c_clk);
        reset = 0;
        check("rst_wait_ready", ifc.in_ready, 1);
        check("rst_wait_valid", ifc.rsp_valid, 0);
        check("rst_wait_req_cmd", ifc.req_cmd_out, 0);
        check("rst_wait_req_data", ifc.req_data_out, 0);
        check("rst_wait_cnt", ifc.timeout_cnt, 0);
        issue(4'd1, 32'd8, 32'd0, 0, 3, code, data, to);
        check("rst_add_data", data, 8);
        finish_rsp(0);
        repeat (3) @(negedge c_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
